// File: rtl/key_debounce_sync.sv
// Two-flop synchronizer plus four-state debounce FSM for a raw pushbutton level.
// Emits a clean registered level, one-cycle rise/fall strobes and a rise counter.
module key_debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMER_W         = 20,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             d,
  input  logic             clr_count,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] press_count
);

  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    PEND1   = 2'd1,
    STABLE1 = 2'd2,
    PEND0   = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);

  logic               r_s1;
  logic               r_s2;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic               r_q;
  logic               w_q_nxt;
  logic               r_rise;
  logic               w_rise_nxt;
  logic               r_fall;
  logic               w_fall_nxt;
  logic [CNT_W-1:0]   r_press_count;
  logic [CNT_W-1:0]   w_press_count_nxt;

  // Synchronizer: only r_s2 is ever seen by the FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= STABLE0;
      r_timer       <= '0;
      r_q           <= 1'b0;
      r_rise        <= 1'b0;
      r_fall        <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_q           <= w_q_nxt;
      r_rise        <= w_rise_nxt;
      r_fall        <= w_fall_nxt;
      r_press_count <= w_press_count_nxt;
    end
  end

  // Timer only advances while a candidate level is pending; any bounce restarts it.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    w_q_nxt     = r_q;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      STABLE0: begin
        if (r_s2) w_state_nxt = PEND1;
      end
      PEND1: begin
        if (!r_s2) begin
          w_state_nxt = STABLE0;
        end else if (r_timer == TIMER_LAST) begin
          w_state_nxt = STABLE1;
          w_q_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end
      STABLE1: begin
        if (!r_s2) w_state_nxt = PEND0;
      end
      PEND0: begin
        if (r_s2) begin
          w_state_nxt = STABLE1;
        end else if (r_timer == TIMER_LAST) begin
          w_state_nxt = STABLE0;
          w_q_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end
      default: begin
        w_state_nxt = STABLE0;
      end
    endcase
  end

  // Clear wins over a coincident rise.
  always_comb begin
    w_press_count_nxt = r_press_count;
    if (clr_count) begin
      w_press_count_nxt = '0;
    end else if (w_rise_nxt) begin
      w_press_count_nxt = r_press_count + CNT_W'(1);
    end
  end

  assign q           = r_q;
  assign rise        = r_rise;
  assign fall        = r_fall;
  assign press_count = r_press_count;

endmodule

// File: tb/tb_key_debounce_sync.sv
// Scoreboard bench for key_debounce_sync: a cycle model of the synchronizer and
// debounce run-length pushes expected outputs, which are popped after each edge.
module tb_key_debounce_sync;

  localparam int DEB = 4;
  localparam int CW  = 8;

  logic          clk;
  logic          resetn;
  logic          d;
  logic          clr_count;
  logic          q;
  logic          rise;
  logic          fall;
  logic [CW-1:0] press_count;

  key_debounce_sync #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMER_W        (20),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .d          (d),
    .clr_count  (clr_count),
    .q          (q),
    .rise       (rise),
    .fall       (fall),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          q;
    logic          rise;
    logic          fall;
    logic [CW-1:0] pc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic          m_s1, m_s2, m_q;
  int            m_run;
  logic [CW-1:0] m_pc;

  int   g_edge = 0;
  int   obs_rise, obs_fall, rise_edge, fall_edge;
  logic clr_on_rise = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, g_edge);
    end
  endtask

  task automatic model_reset();
    m_s1  = 1'b0;
    m_s2  = 1'b0;
    m_q   = 1'b0;
    m_run = 0;
    m_pc  = '0;
    sb.delete();
  endtask

  task automatic clear_obs();
    obs_rise  = 0;
    obs_fall  = 0;
    rise_edge = -1;
    fall_edge = -1;
  endtask

  // One clock: predict, drive, wait for the edge, compare against the popped entry.
  task automatic tick(input logic dv, input logic cv);
    exp_t e;
    logic pr, pf, cv_eff;
    pr     = 1'b0;
    pf     = 1'b0;
    cv_eff = cv;
    // q follows after the synchronized level has differed on DEB+1 consecutive edges
    if (m_s2 != m_q) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_q   = m_s2;
        pr    = m_s2;
        pf    = ~m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (clr_on_rise && pr) cv_eff = 1'b1;
    if (cv_eff)   m_pc = '0;
    else if (pr)  m_pc = m_pc + 8'd1;
    m_s2 = m_s1;
    m_s1 = dv;
    e.q    = m_q;
    e.rise = pr;
    e.fall = pf;
    e.pc   = m_pc;
    sb.push_back(e);

    d         = dv;
    clr_count = cv_eff;
    @(posedge clk);
    #1;
    g_edge++;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("q", {31'd0, q}, {31'd0, e.q});
      chk("rise", {31'd0, rise}, {31'd0, e.rise});
      chk("fall", {31'd0, fall}, {31'd0, e.fall});
      chk("press_count", {24'd0, press_count}, {24'd0, e.pc});
    end
    if (rise === 1'b1) begin obs_rise++; rise_edge = g_edge; end
    if (fall === 1'b1) begin obs_fall++; fall_edge = g_edge; end
  endtask

  task automatic press();
    repeat (8) tick(1'b1, 1'b0);
    repeat (8) tick(1'b0, 1'b0);
  endtask

  int mark;

  initial begin
    resetn    = 1'b1;
    d         = 1'b0;
    clr_count = 1'b0;
    model_reset();
    clear_obs();
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_q", {31'd0, q}, 32'd0);
    chk("rst_rise", {31'd0, rise}, 32'd0);
    chk("rst_fall", {31'd0, fall}, 32'd0);
    chk("rst_pc", {24'd0, press_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Clean press
    repeat (4) tick(1'b0, 1'b0);
    clear_obs();
    mark = g_edge;
    repeat (12) tick(1'b1, 1'b0);
    chk("press_rises", obs_rise, 1);
    chk("press_latency", rise_edge - mark, 7);
    chk("press_falls", obs_fall, 0);
    chk("press_pc", {24'd0, press_count}, 32'd1);

    // Release, then a short high glitch while q=0
    clear_obs();
    mark = g_edge;
    repeat (12) tick(1'b0, 1'b0);
    chk("rel_falls", obs_fall, 1);
    chk("rel_latency", fall_edge - mark, 7);
    chk("rel_q", {31'd0, q}, 32'd0);
    chk("rel_pc", {24'd0, press_count}, 32'd1);
    clear_obs();
    repeat (2) tick(1'b1, 1'b0);
    repeat (10) tick(1'b0, 1'b0);
    chk("glitch2_rises", obs_rise, 0);
    chk("glitch2_falls", obs_fall, 0);

    // Three-cycle glitch
    clear_obs();
    repeat (3) tick(1'b1, 1'b0);
    repeat (10) tick(1'b0, 1'b0);
    chk("glitch3_rises", obs_rise, 0);
    chk("glitch3_pc", {24'd0, press_count}, 32'd1);

    // Bounce 0-1-0-1 before a stable hold
    clear_obs();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    mark = g_edge;
    repeat (12) tick(1'b1, 1'b0);
    chk("bounce_rises", obs_rise, 1);
    chk("bounce_latency", rise_edge - mark, 7);
    chk("bounce_pc", {24'd0, press_count}, 32'd2);
    repeat (12) tick(1'b0, 1'b0);

    // Asynchronous reset between edges with q=1
    repeat (20) tick(1'b1, 1'b0);
    chk("pre_rst_q", {31'd0, q}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_q", {31'd0, q}, 32'd0);
    chk("arst_rise", {31'd0, rise}, 32'd0);
    chk("arst_fall", {31'd0, fall}, 32'd0);
    chk("arst_pc", {24'd0, press_count}, 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_q", {31'd0, q}, 32'd0);
    resetn = 1'b1;
    model_reset();
    clear_obs();
    mark = g_edge;
    repeat (10) tick(1'b1, 1'b0);
    chk("rerise_latency", rise_edge - mark, 7);
    chk("rerise_q", {31'd0, q}, 32'd1);
    repeat (12) tick(1'b0, 1'b0);

    // Wrap
    tick(1'b0, 1'b1);
    chk("wrap_clr", {24'd0, press_count}, 32'd0);
    repeat (255) press();
    chk("wrap_255", {24'd0, press_count}, 32'hFF);
    press();
    chk("wrap_256", {24'd0, press_count}, 32'h00);

    // Clear coincident with a rise
    repeat (2) press();
    chk("pre_clr_pc", {24'd0, press_count}, 32'd2);
    clear_obs();
    clr_on_rise = 1'b1;
    press();
    clr_on_rise = 1'b0;
    chk("clr_rise_pulsed", obs_rise, 1);
    chk("clr_prio_pc", {24'd0, press_count}, 32'd0);

    // Clear alone
    repeat (5) press();
    chk("five_pc", {24'd0, press_count}, 32'd5);
    tick(1'b0, 1'b1);
    chk("clr_alone_pc", {24'd0, press_count}, 32'd0);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce_sync.md
Name: key_debounce_sync

Overview:
- Input-conditioning stage that sits directly upstream of the lab D-latch/flip-flop stage.
- Takes a raw asynchronous pushbutton/switch level and produces a clean, clock-synchronous, debounced level `q`. `q` feeds the downstream storage elements' data input.
- Also produces one-cycle rise/fall strobes and a press counter, so downstream clocked logic can act on events rather than levels.

Parameters:
- DEBOUNCE_CYCLES, 4, cycles the synchronized input must hold a new value before `q` follows; legal range 1..2^TIMER_W.
- TIMER_W, 20, width of the debounce timer.
- CNT_W, 8, width of press_count.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- d  input  1  raw asynchronous input (button/switch), may bounce.
- clr_count  input  1  synchronous clear of press_count.
- q  output  1  debounced, synchronized level (registered).
- rise  output  1  one-cycle pulse when q goes 0->1 (registered).
- fall  output  1  one-cycle pulse when q goes 1->0 (registered).
- press_count  output  CNT_W  number of rise events, modulo 2^CNT_W.

Behaviour:
- Reset: resetn=0 immediately forces the following, independent of clk:
  - s1=0, s2=0, state=STABLE0, timer=0
  - q=0, rise=0, fall=0, press_count=0
- Reset mid-debounce discards any pending transition.
- Synchronizer: two flops, s1<=d, s2<=s1. The FSM reads only s2; d never reaches the FSM or outputs directly.
- FSM states: STABLE0, PEND1, STABLE1, PEND0.
- STABLE0:
  - s2=1 -> PEND1, timer<=0.
  - Otherwise stay.
- PEND1:
  - s2=0 -> STABLE0, timer<=0 (glitch rejected, no pulse).
  - s2=1 and timer==DEBOUNCE_CYCLES-1 -> STABLE1, q<=1, rise<=1.
  - s2=1 otherwise -> timer<=timer+1.
- STABLE1 and PEND0: mirror images of STABLE0 and PEND1 with polarity inverted; fall replaces rise.
- rise and fall default to 0 every cycle. They are asserted only on the transition edge and are never high together.
- Latency: with d stable from before rising edge E1 (the first edge that samples it), q and the strobe change at edge E(DEBOUNCE_CYCLES+3). Example: DEBOUNCE_CYCLES=4 -> edge 7.
- A bounce during PEND returns to the prior STABLE state. Any re-entry into PEND restarts timer at 0; there is no partial credit.
- Timer counts only in PEND states and is held at 0 otherwise.
- press_count:
  - Increments by 1 on the same edge rise is set.
  - Wraps from 2^CNT_W-1 to 0.
  - clr_count=1 sets it to 0 on the next edge and takes priority over a simultaneous increment.
  - fall never changes it.
- Width rule: TIMER_W must represent DEBOUNCE_CYCLES-1. The timer compare is unsigned and full-width.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=8):
- Reset: drive d=1 for 20 cycles so q=1, then pull resetn=0 between edges -> q, rise, fall and press_count read 0 before the next edge. After release with d=1 held, q re-rises 7 edges later.
- Clean press: d 0->1 held 12 cycles -> q=1 and rise=1 for exactly one cycle at the 7th edge after d first sampled; press_count 0->1; fall stays 0.
- Glitch rejection: d high for 3 cycles then low -> q stays 0, rise never asserts, press_count unchanged. Repeat with 0-1-0-1 bouncing before a 12-cycle hold -> exactly one rise, at 7 edges after the final stable 1 is sampled.
- Release: from q=1, d->0 held -> fall pulse at 7th edge and q=0; press_count unchanged; a 2-cycle high glitch while q=0 produces nothing.
- Wrap: 256 clean presses -> press_count reads 0xFF after the 255th and 0x00 after the 256th.
- Clear priority: assert clr_count on the same edge a rise fires -> press_count=0 (not 1) and rise still pulses; clr_count alone with press_count=5 -> 0 next edge.
